// File: rtl/wbu_commit.sv
// Writeback/commit stage: accepts one executed instruction, waits for load data if needed,
// then drives regfile, CSR and next-PC for exactly one commit cycle.
module wbu_commit #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 64
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [XLEN-1:0]   i_pc,
   input  logic [XLEN-1:0]   i_upc,
   input  logic              i_jump,
   input  logic [XLEN-1:0]   i_result,
   input  logic              i_result_t,
   input  logic              i_reg_wen,
   input  logic [4:0]        i_rd,
   input  logic              i_csr_wen,
   input  logic [11:0]       i_csr_addr,
   input  logic [XLEN-1:0]   i_csr_wdata,
   input  logic              i_lsu_valid,
   input  logic [XLEN-1:0]   i_lsu_rdata,
   output logic              o_rf_wen,
   output logic [4:0]        o_rf_waddr,
   output logic [XLEN-1:0]   o_rf_wdata,
   output logic              o_csr_wen,
   output logic [11:0]       o_csr_waddr,
   output logic [XLEN-1:0]   o_csr_wdata,
   output logic              o_commit,
   output logic [XLEN-1:0]   o_next_pc,
   output logic              o_redirect,
   output logic [CNT_W-1:0]  o_retire_cnt,
   output logic              o_lsu_err
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      COMMIT   = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [XLEN-1:0] pc_q, upc_q, wdata_q, csr_wdata_q;
   logic            jump_q, reg_wen_q, csr_wen_q;
   logic [4:0]      rd_q;
   logic [11:0]     csr_addr_q;
   logic            accept;

   assign accept = i_valid && (state_q == IDLE);

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (i_valid) state_d = i_result_t ? WAIT_MEM : COMMIT;
         WAIT_MEM: if (i_lsu_valid) state_d = COMMIT;
         COMMIT:   state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // wdata_q first holds the ALU result; a load overwrites it with the LSU response
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         pc_q        <= '0;
         upc_q       <= '0;
         jump_q      <= 1'b0;
         wdata_q     <= '0;
         reg_wen_q   <= 1'b0;
         rd_q        <= '0;
         csr_wen_q   <= 1'b0;
         csr_addr_q  <= '0;
         csr_wdata_q <= '0;
      end else if (accept) begin
         pc_q        <= i_pc;
         upc_q       <= i_upc;
         jump_q      <= i_jump;
         wdata_q     <= i_result;
         reg_wen_q   <= i_reg_wen;
         rd_q        <= i_rd;
         csr_wen_q   <= i_csr_wen;
         csr_addr_q  <= i_csr_addr;
         csr_wdata_q <= i_csr_wdata;
      end else if (state_q == WAIT_MEM && i_lsu_valid) begin
         wdata_q     <= i_lsu_rdata;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         o_retire_cnt <= '0;
         o_lsu_err    <= 1'b0;
      end else begin
         if (state_q == COMMIT) o_retire_cnt <= o_retire_cnt + CNT_W'(1);
         if (i_lsu_valid && state_q != WAIT_MEM) o_lsu_err <= 1'b1;
      end
   end

   always_comb begin
      o_ready     = (state_q == IDLE);
      o_commit    = (state_q == COMMIT);
      o_rf_wen    = (state_q == COMMIT) && reg_wen_q && (rd_q != 5'd0);
      o_csr_wen   = (state_q == COMMIT) && csr_wen_q;
      o_redirect  = (state_q == COMMIT) && jump_q;
      o_rf_waddr  = rd_q;
      o_rf_wdata  = wdata_q;
      o_csr_waddr = csr_addr_q;
      o_csr_wdata = csr_wdata_q;
      o_next_pc   = jump_q ? upc_q : pc_q + XLEN'(4);
   end

endmodule

// File: doc/wbu_commit.md
Name: wbu_commit

Overview:
- Writeback/commit stage. It is the consumer end of the EXU control handshake.
- Accepts one executed instruction per handshake: target PC, result, result type, regfile/CSR write enables, jump flag.
- For loads, waits for the LSU read response. Then, in a single commit cycle, drives the regfile write port, the CSR write port and the next-PC/redirect to the IFU.
- Maintains a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 64, width of retired-instruction counter.

Ports:
- i_clock  input  1  clock.
- i_reset  input  1  asynchronous active-high reset.
- i_valid  input  1  EXU presents an executed instruction.
- o_ready  output  1  WBU can accept (IDLE only).
- i_pc  input  XLEN  PC of the instruction.
- i_upc  input  XLEN  jump/branch/trap target.
- i_jump  input  1  take i_upc as next PC.
- i_result  input  XLEN  ALU/CSR-read result.
- i_result_t  input  1  0 = result from i_result, 1 = result from LSU load.
- i_reg_wen  input  1  write rd.
- i_rd  input  5  destination register.
- i_csr_wen  input  1  write CSR.
- i_csr_addr  input  12  CSR address.
- i_csr_wdata  input  XLEN  CSR write value.
- i_lsu_valid  input  1  load data valid (single-cycle pulse).
- i_lsu_rdata  input  XLEN  load data.
- o_rf_wen  output  1  regfile write strobe.
- o_rf_waddr  output  5  regfile address.
- o_rf_wdata  output  XLEN  regfile data.
- o_csr_wen  output  1  CSR write strobe.
- o_csr_waddr  output  12  CSR address.
- o_csr_wdata  output  XLEN  CSR data.
- o_commit  output  1  one-cycle pulse: instruction retired, IFU may fetch.
- o_next_pc  output  XLEN  next fetch PC, valid with o_commit.
- o_redirect  output  1  o_commit caused by jump (next PC not i_pc+4).
- o_retire_cnt  output  CNT_W  retired instruction count.
- o_lsu_err  output  1  sticky: i_lsu_valid seen outside WAIT_MEM.

Behaviour:
- States: IDLE, WAIT_MEM, COMMIT. Encoding is free.
- Reset (asynchronous, any state, mid-load included):
  - State goes to IDLE.
  - All registered fields and o_retire_cnt go to 0; o_lsu_err goes to 0.
  - A load pending at reset is dropped. A late i_lsu_valid after reset release sets o_lsu_err.
- o_ready = 1 only in IDLE (combinational from state). Its value is 1 in the first cycle after reset release.
- IDLE:
  - On i_valid & o_ready, latch all i_* instruction fields.
  - Go to COMMIT if i_result_t = 0, else WAIT_MEM.
  - i_valid while not ready is held by the EXU; it is not sampled.
- WAIT_MEM:
  - On i_lsu_valid, latch i_lsu_rdata as the writeback data and go to COMMIT.
  - Otherwise stay, with no timeout.
- COMMIT (exactly one cycle):
  - o_commit = 1.
  - o_rf_wen = latched reg_wen & (rd != 0). x0 is never written.
  - o_rf_wdata = load data if result_t, else latched result.
  - o_csr_wen = latched csr_wen. CSR and RF writes may coincide.
  - o_next_pc = upc if jump, else pc + 4 (mod 2^XLEN, wraps 0xFFFFFFFC -> 0x0). o_redirect = jump.
  - Transition to IDLE. o_retire_cnt increments by 1 at the clock edge ending COMMIT, wrapping at 2^CNT_W.
- Outside COMMIT:
  - o_commit, o_rf_wen, o_csr_wen and o_redirect are 0.
  - Address, data and o_next_pc outputs hold their last registered values (don't-care to consumers).
- Minimum latency (accept edge to o_commit high):
  - 1 cycle for a non-load.
  - Load: 1 cycle after the i_lsu_valid edge.
  - Throughput is at most one instruction per 2 cycles.
- i_lsu_valid in IDLE or COMMIT is ignored for data and sets o_lsu_err. o_lsu_err clears only on reset.
- The trap path arrives as i_jump = 1 with i_upc = trap vector. No special handling.

Test Plan:
- Reset release, then ALU op: pc=0x80000000, result=0x1234, rd=5, reg_wen=1, jump=0.
  - Next cycle: o_commit=1, o_rf_wen=1, waddr=5, wdata=0x1234, o_next_pc=0x80000004, o_redirect=0.
  - Afterwards o_retire_cnt=1 and o_ready=1.
- Load: result_t=1, rd=10, LSU responds 3 cycles later with 0xDEADBEEF.
  - o_ready=0 throughout the wait.
  - o_commit one cycle after i_lsu_valid, with wdata=0xDEADBEEF and waddr=10.
- Branch taken: jump=1, upc=0x80000100, reg_wen=0 -> o_commit=1, o_redirect=1, o_next_pc=0x80000100, o_rf_wen=0.
- Instruction with rd=0, reg_wen=1, csr_wen=1, csr_addr=0x305, csr_wdata=0x80000000 -> o_rf_wen=0, o_csr_wen=1, o_csr_waddr=0x305 in the commit cycle.
- Reset asserted during WAIT_MEM:
  - o_ready=1 after release and o_retire_cnt=0.
  - A subsequent stray i_lsu_valid sets o_lsu_err=1 with no commit.
- pc=0xFFFFFFFC, jump=0 -> o_next_pc=0x00000000.
- 10 back-to-back ALU ops with i_valid held high -> 10 o_commit pulses, each separated by at least 1 idle cycle, and o_retire_cnt=10.
